// File: rtl/adder.sv
// ---------------------------------------------------------------------------
// adder : AXI4-Lite-style register slave around a DATA_WIDTH-bit adder.
//
// Software writes operands A and B, then reads SUM and STATUS.
//   0x00 A      RW
//   0x04 B      RW
//   0x08 CTRL   RW (only when ADDER_SUB_EN is defined; bit0 = subtract)
//   0x18 SUM    RO  (A+B or A-B) mod 2^DATA_WIDTH
//   0x1C STATUS RO  bit0 carry-out / borrow, bit1 signed overflow
// Any other, RO or unaligned address answers SLVERR (resp = 1).
//
// Optional feature macro: ADDER_SUB_EN (adds CTRL and the subtract mode).
//
// Ports
//   s1_axi_aclk / s1_axi_aresetn : clock, async active-low reset
//   s1_axi_aw* / s1_axi_w*       : write address / data (wstrb MSB ignored)
//   s1_axi_b*                    : write response
//   s1_axi_ar* / s1_axi_r*       : read address / read data
//
// Handshake: a channel raises its ready for one cycle after it sees the
// request; the transfer completes on that cycle's edge and the response is
// valid on the following cycle, held until the master accepts it.
// ---------------------------------------------------------------------------
module adder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8:0]   s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic                    s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic                    s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A      = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B      = ADDR_WIDTH'(8'h04);
`ifdef ADDER_SUB_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = ADDR_WIDTH'(8'h08);
`endif
  localparam logic [ADDR_WIDTH-1:0] ADDR_SUM    = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(8'h1C);

  typedef enum logic {WR_IDLE = 1'b0, WR_RESP = 1'b1} wr_state_t;
  typedef enum logic {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_t;

  wr_state_t               wr_state_r;
  rd_state_t               rd_state_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic                    awready_r;
  logic                    wready_r;
  logic                    bvalid_r;
  logic                    bresp_r;
  logic                    arready_r;
  logic                    rvalid_r;
  logic                    rresp_r;
  logic [DATA_WIDTH-1:0]   rdata_r;
`ifdef ADDER_SUB_EN
  logic                    ctrl_op_r;
`endif

  logic                    op_sub_s;
  logic [DATA_WIDTH:0]     sum_ext_s;
  logic                    ovf_s;
  logic [DATA_WIDTH-1:0]   status_s;
  logic                    wr_sel_a_s;
  logic                    wr_sel_b_s;
  logic                    wr_sel_ctrl_s;
  logic                    wr_err_s;
  logic [DATA_WIDTH-1:0]   rd_data_s;
  logic                    rd_err_s;
  logic                    unused_strb_s;

  // Byte-lane merge: lanes with their strobe set take the new data.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [NB-1:0]         strb
  );
    logic [DATA_WIDTH-1:0] res;
    for (int i = 0; i < NB; i++) begin
      res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

  assign unused_strb_s = s1_axi_wstrb[NB];

`ifdef ADDER_SUB_EN
  assign op_sub_s = ctrl_op_r;
`else
  assign op_sub_s = 1'b0;
`endif

  // Arithmetic core; the extra MSB is carry-out on add and borrow on subtract.
  always_comb begin
    if (op_sub_s) begin
      sum_ext_s = {1'b0, a_r} - {1'b0, b_r};
      ovf_s     = (a_r[DATA_WIDTH-1] != b_r[DATA_WIDTH-1]) &&
                  (sum_ext_s[DATA_WIDTH-1] != a_r[DATA_WIDTH-1]);
    end else begin
      sum_ext_s = {1'b0, a_r} + {1'b0, b_r};
      ovf_s     = (a_r[DATA_WIDTH-1] == b_r[DATA_WIDTH-1]) &&
                  (sum_ext_s[DATA_WIDTH-1] != a_r[DATA_WIDTH-1]);
    end
    status_s = {{(DATA_WIDTH-2){1'b0}}, ovf_s, sum_ext_s[DATA_WIDTH]};
  end

  // Write address decode; full-address match also enforces alignment.
  always_comb begin
    wr_sel_a_s    = 1'b0;
    wr_sel_b_s    = 1'b0;
    wr_sel_ctrl_s = 1'b0;
    case (s1_axi_awaddr)
      ADDR_A:    wr_sel_a_s    = 1'b1;
      ADDR_B:    wr_sel_b_s    = 1'b1;
`ifdef ADDER_SUB_EN
      ADDR_CTRL: wr_sel_ctrl_s = 1'b1;
`endif
      default:   wr_sel_a_s    = 1'b0;
    endcase
    wr_err_s = !(wr_sel_a_s || wr_sel_b_s || wr_sel_ctrl_s);
  end

  // Read data mux; unmapped addresses return zero with SLVERR.
  always_comb begin
    rd_data_s = '0;
    rd_err_s  = 1'b0;
    case (s1_axi_araddr)
      ADDR_A:      rd_data_s = a_r;
      ADDR_B:      rd_data_s = b_r;
`ifdef ADDER_SUB_EN
      ADDR_CTRL:   rd_data_s = {{(DATA_WIDTH-1){1'b0}}, ctrl_op_r};
`endif
      ADDR_SUM:    rd_data_s = sum_ext_s[DATA_WIDTH-1:0];
      ADDR_STATUS: rd_data_s = status_s;
      default: begin
        rd_data_s = '0;
        rd_err_s  = 1'b1;
      end
    endcase
  end

  // Write channel FSM and operand registers.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      wr_state_r <= WR_IDLE;
      awready_r  <= 1'b0;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
`ifdef ADDER_SUB_EN
      ctrl_op_r  <= 1'b0;
`endif
    end else begin
      case (wr_state_r)
        WR_IDLE: begin
          if (awready_r) begin
            // Ready was up this cycle: this edge is the handshake.
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            if (s1_axi_awvalid && s1_axi_wvalid) begin
              if (wr_sel_a_s) a_r <= merge_bytes(a_r, s1_axi_wdata, s1_axi_wstrb[NB-1:0]);
              if (wr_sel_b_s) b_r <= merge_bytes(b_r, s1_axi_wdata, s1_axi_wstrb[NB-1:0]);
`ifdef ADDER_SUB_EN
              if (wr_sel_ctrl_s && s1_axi_wstrb[0]) ctrl_op_r <= s1_axi_wdata[0];
`endif
              bresp_r    <= wr_err_s;
              bvalid_r   <= 1'b1;
              wr_state_r <= WR_RESP;
            end
          end else if (s1_axi_awvalid && s1_axi_wvalid && !bvalid_r) begin
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
          end
        end
        WR_RESP: begin
          if (s1_axi_bready) begin
            bvalid_r   <= 1'b0;
            bresp_r    <= 1'b0;
            wr_state_r <= WR_IDLE;
          end
        end
        default: begin
          wr_state_r <= WR_IDLE;
          awready_r  <= 1'b0;
          wready_r   <= 1'b0;
          bvalid_r   <= 1'b0;
          bresp_r    <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM; data captured on the handshake edge.
  always_ff @(posedge s1_axi_aclk or negedge s1_axi_aresetn) begin
    if (!s1_axi_aresetn) begin
      rd_state_r <= RD_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= 1'b0;
      rdata_r    <= '0;
    end else begin
      case (rd_state_r)
        RD_IDLE: begin
          if (arready_r) begin
            arready_r <= 1'b0;
            if (s1_axi_arvalid) begin
              rdata_r    <= rd_data_s;
              rresp_r    <= rd_err_s;
              rvalid_r   <= 1'b1;
              rd_state_r <= RD_DATA;
            end
          end else if (s1_axi_arvalid && !rvalid_r) begin
            arready_r <= 1'b1;
          end
        end
        RD_DATA: begin
          if (s1_axi_rready) begin
            rvalid_r   <= 1'b0;
            rresp_r    <= 1'b0;
            rdata_r    <= '0;
            rd_state_r <= RD_IDLE;
          end
        end
        default: begin
          rd_state_r <= RD_IDLE;
          arready_r  <= 1'b0;
          rvalid_r   <= 1'b0;
          rresp_r    <= 1'b0;
          rdata_r    <= '0;
        end
      endcase
    end
  end

  assign s1_axi_awready = awready_r;
  assign s1_axi_wready  = wready_r;
  assign s1_axi_bvalid  = bvalid_r;
  assign s1_axi_bresp   = bresp_r;
  assign s1_axi_arready = arready_r;
  assign s1_axi_rvalid  = rvalid_r;
  assign s1_axi_rresp   = rresp_r;
  assign s1_axi_rdata   = rdata_r;

endmodule

// File: tb/tb_adder.sv
// ---------------------------------------------------------------------------
// tb_adder : self-checking bench for the adder register slave.
// Reference model keeps A, B and the op bit as plain variables and derives
// SUM/STATUS with 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_adder;

  logic        clk;
  logic        rst_n;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [4:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready;

  int n_cmp;
  int n_err;

  // reference model state
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_op;

  adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (rst_n),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_sum();
    longint r;
    if (m_op) r = longint'(m_a) - longint'(m_b);
    else      r = longint'(m_a) + longint'(m_b);
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_status();
    longint sa, sb, sr;
    logic   cy, ov;
    sa = longint'($signed(m_a));
    sb = longint'($signed(m_b));
    if (m_op) begin
      cy = (m_a < m_b);
      sr = sa - sb;
    end else begin
      cy = ((longint'(m_a) + longint'(m_b)) > 64'sd4294967295);
      sr = sa + sb;
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {30'd0, ov, cy};
  endfunction

  function automatic logic m_wr_err(input logic [7:0] addr);
    if (addr == 8'h00 || addr == 8'h04) return 1'b0;
`ifdef ADDER_SUB_EN
    if (addr == 8'h08) return 1'b0;
`endif
    return 1'b1;
  endfunction

  task automatic m_write(input logic [7:0] addr, input logic [31:0] d, input logic [4:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        if (addr == 8'h00) m_a[i*8 +: 8] = d[i*8 +: 8];
        if (addr == 8'h04) m_b[i*8 +: 8] = d[i*8 +: 8];
      end
    end
`ifdef ADDER_SUB_EN
    if (addr == 8'h08 && s[0]) m_op = d[0];
`endif
  endtask

  task automatic m_read(input logic [7:0] addr, output logic [31:0] d, output logic e);
    e = 1'b0;
    case (addr)
      8'h00: d = m_a;
      8'h04: d = m_b;
`ifdef ADDER_SUB_EN
      8'h08: d = {31'd0, m_op};
`endif
      8'h18: d = m_sum();
      8'h1C: d = m_status();
      default: begin d = 32'd0; e = 1'b1; end
    endcase
  endtask

  // ---------------- bus transactions ----------------
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] d, input logic [4:0] s,
                           input bit wait_resp, output logic resp);
    bit got;
    resp = 1'b0;
    awaddr = addr; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (awready && wready) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL wr_accept_timeout addr=%h: awready/wready never rose", addr);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 awvalid = 1'b0; wvalid = 1'b0;
    m_write(addr, d, s);
    @(negedge clk);
    n_cmp++;
    if ({bvalid, awready, wready} !== 3'b100) begin
      n_err++;
      $display("FAIL wr_latency addr=%h: bvalid,awready,wready=%b required 100", addr,
               {bvalid, awready, wready});
    end
    resp = bresp;
    if (wait_resp) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (bvalid && bready) got = 1'b1;
        else @(negedge clk);
      end
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL wr_resp_timeout addr=%h", addr);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_read(input logic [7:0] addr, input bit wait_resp,
                          output logic [31:0] d, output logic e);
    bit got;
    d = 32'd0; e = 1'b0;
    araddr = addr; arvalid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (arready) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL rd_accept_timeout addr=%h", addr);
      arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 arvalid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rvalid, arready} !== 2'b10) begin
      n_err++;
      $display("FAIL rd_latency addr=%h: rvalid,arready=%b required 10", addr, {rvalid, arready});
    end
    d = rdata; e = rresp;
    if (wait_resp) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        if (rvalid && rready) got = 1'b1;
        else @(negedge clk);
      end
      n_cmp++;
      if (!got) begin
        n_err++;
        $display("FAIL rd_resp_timeout addr=%h", addr);
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] d; logic e;
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = 8'h00; araddr = 8'h00; wdata = 32'd0; wstrb = 5'd0;
    bready = 1'b1; rready = 1'b1;
    m_a = 32'd0; m_b = 32'd0; m_op = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h required 0",
               {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata});
    end
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(8'h00, 1'b1, d, e);
    n_cmp++;
    if ({e, d} !== 33'd0) begin n_err++; $display("FAIL reset_a: got %h/%b required 0/0", d, e); end
    axi_read(8'h1C, 1'b1, d, e);
    n_cmp++;
    if ({e, d} !== 33'd0) begin n_err++; $display("FAIL reset_status: got %h/%b required 0/0", d, e); end
  endtask

  task automatic test_basic();
    logic r; logic [31:0] d; logic e;
    axi_write(8'h00, 32'd39, 5'h0F, 1'b1, r);
    n_cmp++;
    if (r !== 1'b0) begin n_err++; $display("FAIL basic_bresp_a: got %b required 0", r); end
    axi_write(8'h04, 32'd40, 5'h0F, 1'b1, r);
    n_cmp++;
    if (r !== 1'b0) begin n_err++; $display("FAIL basic_bresp_b: got %b required 0", r); end
    axi_read(8'h18, 1'b1, d, e);
    n_cmp++;
    if ({e, d} !== {1'b0, 32'd79}) begin n_err++; $display("FAIL basic_sum: got %0d/%b required 79/0", d, e); end
    axi_read(8'h1C, 1'b1, d, e);
    n_cmp++;
    if ({e, d} !== 33'd0) begin n_err++; $display("FAIL basic_status: got %h/%b required 0/0", d, e); end
  endtask

  task automatic test_flags();
    logic r; logic [31:0] d; logic e;
    axi_write(8'h00, 32'hFFFFFFFF, 5'h0F, 1'b1, r);
    axi_write(8'h04, 32'h00000001, 5'h0F, 1'b1, r);
    axi_read(8'h18, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'h0) begin n_err++; $display("FAIL carry_sum: got %h required 0", d); end
    axi_read(8'h1C, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'h1) begin n_err++; $display("FAIL carry_status: got %h required 1", d); end
    axi_write(8'h00, 32'h7FFFFFFF, 5'h0F, 1'b1, r);
    axi_read(8'h18, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'h80000000) begin n_err++; $display("FAIL ovf_sum: got %h required 80000000", d); end
    axi_read(8'h1C, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'h2) begin n_err++; $display("FAIL ovf_status: got %h required 2", d); end
  endtask

  task automatic test_errors();
    logic r; logic [31:0] d; logic e; logic [31:0] xd; logic xe;
    axi_write(8'h23, 32'd76, 5'h0F, 1'b1, r);
    n_cmp++;
    if (r !== 1'b1) begin n_err++; $display("FAIL unaligned_bresp: got %b required 1", r); end
    axi_read(8'h00, 1'b1, d, e);
    n_cmp++;
    if (d !== m_a) begin n_err++; $display("FAIL unaligned_a_kept: got %h required %h", d, m_a); end
    axi_read(8'h04, 1'b1, d, e);
    n_cmp++;
    if (d !== m_b) begin n_err++; $display("FAIL unaligned_b_kept: got %h required %h", d, m_b); end
    axi_read(8'h20, 1'b1, d, e);
    n_cmp++;
    if ({e, d} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL unmapped_read: got %h/%b required 0/1", d, e); end
    axi_write(8'h18, 32'd5, 5'h0F, 1'b1, r);
    n_cmp++;
    if (r !== 1'b1) begin n_err++; $display("FAIL ro_write_bresp: got %b required 1", r); end
    axi_write(8'h08, 32'd0, 5'h0F, 1'b1, r);
    n_cmp++;
    if (r !== m_wr_err(8'h08)) begin n_err++; $display("FAIL ctrl_write_bresp: got %b required %b", r, m_wr_err(8'h08)); end
    axi_read(8'h08, 1'b1, d, e);
    m_read(8'h08, xd, xe);
    n_cmp++;
    if ({e, d} !== {xe, xd}) begin n_err++; $display("FAIL ctrl_read: got %h/%b required %h/%b", d, e, xd, xe); end
  endtask

  task automatic test_strobe();
    logic r; logic [31:0] d; logic e;
    axi_write(8'h00, 32'h11223344, 5'h0F, 1'b1, r);
    axi_write(8'h00, 32'hAABBCCDD, 5'h05, 1'b1, r);
    axi_read(8'h00, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'h11BB33DD) begin n_err++; $display("FAIL strobe_merge: got %h required 11BB33DD", d); end
    axi_write(8'h00, 32'h01020304, 5'h10, 1'b1, r);
    n_cmp++;
    if (r !== 1'b0) begin n_err++; $display("FAIL strobe_zero_bresp: got %b required 0", r); end
    axi_read(8'h00, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'h11BB33DD) begin n_err++; $display("FAIL strobe_zero_kept: got %h required 11BB33DD", d); end
  endtask

  task automatic test_stall();
    logic r; logic held; logic [31:0] d; logic e; logic [31:0] hd;
    bready = 1'b0;
    axi_write(8'h00, 32'h12345678, 5'h0F, 1'b0, r);
    held = r;
    awaddr = 8'h04; wdata = 32'h0000DEAD; wstrb = 5'h0F; awvalid = 1'b1; wvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, held, 2'b00}) begin
        n_err++;
        $display("FAIL wr_stall cyc%0d: bvalid,bresp,awready,wready=%b", k, {bvalid, bresp, awready, wready});
      end
    end
    bready = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bvalid !== 1'b0) begin n_err++; $display("FAIL wr_release: bvalid=%b required 0", bvalid); end
    @(negedge clk);
    axi_read(8'h04, 1'b1, d, e);
    n_cmp++;
    if (d !== m_b) begin n_err++; $display("FAIL wr_stall_no_accept: B=%h required %h", d, m_b); end

    rready = 1'b0;
    axi_read(8'h00, 1'b0, hd, e);
    n_cmp++;
    if (hd !== m_a) begin n_err++; $display("FAIL rd_stall_data: got %h required %h", hd, m_a); end
    araddr = 8'h04; arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({rvalid, arready, rdata} !== {2'b10, hd}) begin
        n_err++;
        $display("FAIL rd_stall cyc%0d: rvalid,arready=%b rdata=%h", k, {rvalid, arready}, rdata);
      end
    end
    rready = 1'b1; arvalid = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL rd_release: rvalid=%b required 0", rvalid); end
    @(negedge clk);
  endtask

  task automatic test_sub();
`ifdef ADDER_SUB_EN
    logic r; logic [31:0] d; logic e;
    axi_write(8'h08, 32'h1, 5'h0F, 1'b1, r);
    axi_write(8'h00, 32'd5, 5'h0F, 1'b1, r);
    axi_write(8'h04, 32'd7, 5'h0F, 1'b1, r);
    axi_read(8'h18, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'hFFFFFFFE) begin n_err++; $display("FAIL sub_sum: got %h required FFFFFFFE", d); end
    axi_read(8'h1C, 1'b1, d, e);
    n_cmp++;
    if (d[0] !== 1'b1) begin n_err++; $display("FAIL sub_borrow: got %h required bit0=1", d); end
    axi_write(8'h08, 32'hFFFFFFFE, 5'h0F, 1'b1, r);
    axi_read(8'h08, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL ctrl_upper_bits: got %h required 0", d); end
`endif
  endtask

  task automatic test_random();
    logic r; logic [31:0] d; logic e; logic [31:0] xd; logic xe;
    logic [7:0] addr; logic [31:0] data; logic [4:0] strb; logic xr;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 7))
        0, 6:    addr = 8'h00;
        1, 7:    addr = 8'h04;
        2:       addr = 8'h08;
        3:       addr = 8'h18;
        4:       addr = 8'h1C;
        default: addr = 8'($urandom_range(0, 255));
      endcase
      data = $urandom;
      strb = 5'($urandom_range(0, 31));
      xr = m_wr_err(addr);
      axi_write(addr, data, strb, 1'b1, r);
      n_cmp++;
      if (r !== xr) begin n_err++; $display("FAIL rnd_bresp it%0d addr=%h: got %b required %b", it, addr, r, xr); end
      axi_read(8'h18, 1'b1, d, e);
      n_cmp++;
      if (d !== m_sum()) begin n_err++; $display("FAIL rnd_sum it%0d: got %h required %h", it, d, m_sum()); end
      axi_read(8'h1C, 1'b1, d, e);
      n_cmp++;
      if (d !== m_status()) begin n_err++; $display("FAIL rnd_status it%0d: got %h required %h", it, d, m_status()); end
      addr = 8'($urandom_range(0, 35));
      axi_read(addr, 1'b1, d, e);
      m_read(addr, xd, xe);
      n_cmp++;
      if ({e, d} !== {xe, xd}) begin
        n_err++;
        $display("FAIL rnd_read it%0d addr=%h: got %h/%b required %h/%b", it, addr, d, e, xd, xe);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic r; logic [31:0] d; logic e;
    bready = 1'b0; rready = 1'b0;
    axi_write(8'h04, 32'hCAFE0001, 5'h0F, 1'b0, r);
    axi_read(8'h04, 1'b0, d, e);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h required 0",
               {awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata});
    end
    m_a = 32'd0; m_b = 32'd0; m_op = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    axi_read(8'h04, 1'b1, d, e);
    n_cmp++;
    if (d !== 32'd0) begin n_err++; $display("FAIL reset_mid_b: got %h required 0", d); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_flags();
    test_errors();
    test_strobe();
    test_stall();
    test_sub();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
